// File: rtl/fb_zoom_writer_pkg.sv
// Shared definitions for the zoomed framebuffer writer: bus widths, default
// source geometry and the writer's state encoding.
package fb_zoom_writer_pkg;

  localparam int unsigned FB_AW     = 19;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned DEF_SRC_W = 160;
  localparam int unsigned DEF_SRC_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_pipe_delay.sv
// Fixed-depth shift line carrying a valid bit and a payload, with a
// synchronous clear that drops everything in flight.
module fb_pipe_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid_c
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign any_valid_c = |valid_q;

endmodule

// File: rtl/fb_zoom_writer.sv
// Copies a grey ROM image into the framebuffer RAM with SCALE x SCALE
// nearest-neighbour replication, one destination pixel per clock.
module fb_zoom_writer
  import fb_zoom_writer_pkg::*;
#(
  parameter int unsigned SRC_W    = DEF_SRC_W,
  parameter int unsigned SRC_H    = DEF_SRC_H,
  parameter int unsigned SCALE_LG = 1,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned AW       = FB_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic [AW-1:0]    ram_wraddr,
  output logic [PIX_W-1:0] ram_data,
  output logic             ram_wren
);

  localparam int unsigned DST_W      = SRC_W << SCALE_LG;
  localparam int unsigned DST_H      = SRC_H << SCALE_LG;
  localparam int unsigned PIPE_DEPTH = ROM_LAT + 1;

  fb_state_t      state_q, state_n;
  logic [AW-1:0]  dx_q, dy_q;
  logic           issue_c, last_c, pipe_busy_c;
  logic [AW-1:0]  src_addr_c, dst_addr_c;
  logic           tail_valid;
  logic [AW-1:0]  tail_addr;

  assign last_c     = (dx_q == AW'(DST_W - 1)) && (dy_q == AW'(DST_H - 1));
  assign src_addr_c = ((dy_q >> SCALE_LG) * AW'(SRC_W)) + (dx_q >> SCALE_LG);
  assign dst_addr_c = (dy_q * AW'(DST_W)) + dx_q;

  // Next state; only IDLE accepts start so pulses during a frame or on done are dropped.
  always_comb begin
    state_n = state_q;
    issue_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN: begin
        issue_c = 1'b1;
        if (last_c) state_n = ST_DRAIN;
      end
      ST_DRAIN: if (!pipe_busy_c) state_n = ST_FIN;
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Destination address rides alongside the ROM read so it lines up with rom_data.
  fb_pipe_delay #(
    .DEPTH(PIPE_DEPTH),
    .WIDTH(AW)
  ) u_pipe (
    .clock      (clock),
    .clear      (reset),
    .in_valid   (issue_c),
    .in_data    (dst_addr_c),
    .out_valid  (tail_valid),
    .out_data   (tail_addr),
    .any_valid_c(pipe_busy_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      rom_addr   <= '0;
      ram_wraddr <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done    <= (state_n == ST_FIN);
      // Raster walk over the destination; wraps back to 0,0 after the last pixel.
      if (issue_c) begin
        rom_addr <= src_addr_c;
        if (dx_q == AW'(DST_W - 1)) begin
          dx_q <= '0;
          dy_q <= (dy_q == AW'(DST_H - 1)) ? '0 : dy_q + AW'(1);
        end else begin
          dx_q <= dx_q + AW'(1);
        end
      end
      ram_wren <= tail_valid;
      if (tail_valid) begin
        ram_wraddr <= tail_addr;
        ram_data   <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_zoom_writer.sv
// Scoreboard bench for fb_zoom_writer: three configurations run side by side,
// expected RAM writes derived from the zoom rule and checked as they appear.
module tb_fb_zoom_writer;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  localparam int A_W = 4,   A_H = 2,   A_S = 1, A_L = 1, A_N = (A_W << A_S) * (A_H << A_S);
  localparam int B_W = 4,   B_H = 2,   B_S = 0, B_L = 2, B_N = (B_W << B_S) * (B_H << B_S);
  localparam int C_W = 160, C_H = 120, C_S = 1, C_L = 3, C_N = (C_W << C_S) * (C_H << C_S);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        reset_a, reset_bc, start_a, start_b, start_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [18:0] rom_addr_a, rom_addr_b, rom_addr_c;
  logic [7:0]  rom_data_a, rom_data_b, rom_data_c;
  logic [18:0] ram_wraddr_a, ram_wraddr_b, ram_wraddr_c;
  logic [7:0]  ram_data_a, ram_data_b, ram_data_c;
  logic        ram_wren_a, ram_wren_b, ram_wren_c;

  fb_zoom_writer #(.SRC_W(A_W), .SRC_H(A_H), .SCALE_LG(A_S), .ROM_LAT(A_L)) u_a (
    .clock(clock), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .ram_wraddr(ram_wraddr_a),
    .ram_data(ram_data_a), .ram_wren(ram_wren_a));

  fb_zoom_writer #(.SRC_W(B_W), .SRC_H(B_H), .SCALE_LG(B_S), .ROM_LAT(B_L)) u_b (
    .clock(clock), .reset(reset_bc), .start(start_b), .busy(busy_b), .done(done_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .ram_wraddr(ram_wraddr_b),
    .ram_data(ram_data_b), .ram_wren(ram_wren_b));

  fb_zoom_writer #(.SRC_W(C_W), .SRC_H(C_H), .SCALE_LG(C_S), .ROM_LAT(C_L)) u_c (
    .clock(clock), .reset(reset_bc), .start(start_c), .busy(busy_c), .done(done_c),
    .rom_addr(rom_addr_c), .rom_data(rom_data_c), .ram_wraddr(ram_wraddr_c),
    .ram_data(ram_data_c), .ram_wren(ram_wren_c));

  // ROM models: data = addr[7:0], visible ROM_LAT clocks after the address changes.
  logic [7:0] rb0, rc0, rc1;
  always @(posedge clock) begin
    rom_data_a <= rom_addr_a[7:0];
    rb0        <= rom_addr_b[7:0];
    rom_data_b <= rb0;
    rc0        <= rom_addr_c[7:0];
    rc1        <= rc0;
    rom_data_c <= rc1;
  end

  wr_t q_a[$], q_b[$], q_c[$];
  int  checks = 0, failures = 0;
  int  wr_a = 0, wr_b = 0, wr_c = 0;
  int  dones_a = 0, dones_b = 0, dones_c = 0;
  int  done_cyc_b = -1, done_cyc_c = -1;
  int  busy_cnt_a = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: destination pixel k samples source (y/scale, x/scale).
  task automatic push_frame(input int id);
    int sw, s, dw, n, x, y, src;
    wr_t e;
    case (id)
      0:       begin sw = A_W; s = A_S; dw = A_W << A_S; n = A_N; end
      1:       begin sw = B_W; s = B_S; dw = B_W << B_S; n = B_N; end
      default: begin sw = C_W; s = C_S; dw = C_W << C_S; n = C_N; end
    endcase
    for (int k = 0; k < n; k++) begin
      x = k % dw;
      y = k / dw;
      src = (y / (1 << s)) * sw + x / (1 << s);
      e.addr = 19'(k);
      e.data = 8'(src);
      case (id)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  // Monitors: pop the expected write whenever a strobe appears.
  initial forever begin : mon_a
    wr_t e;
    @(negedge clock);
    if (busy_a) busy_cnt_a++;
    if (done_a) dones_a++;
    if (ram_wren_a) begin
      wr_a++;
      check("a_wren_only_while_busy", busy_a, 1);
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_write: addr %0d data %0d, expected no write", ram_wraddr_a, ram_data_a);
      end else begin
        e = q_a.pop_front();
        check("a_wr_addr", ram_wraddr_a, e.addr);
        check("a_wr_data", ram_data_a, e.data);
      end
    end
  end

  initial forever begin : mon_b
    wr_t e;
    @(negedge clock);
    if (done_b) begin dones_b++; done_cyc_b = cyc; end
    if (ram_wren_b) begin
      wr_b++;
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_write: addr %0d, expected no write", ram_wraddr_b);
      end else begin
        e = q_b.pop_front();
        check("b_wr_addr", ram_wraddr_b, e.addr);
        check("b_wr_data", ram_data_b, e.data);
      end
    end
  end

  initial forever begin : mon_c
    wr_t e;
    @(negedge clock);
    if (done_c) begin dones_c++; done_cyc_c = cyc; end
    if (ram_wren_c) begin
      wr_c++;
      if (ram_wraddr_c == 19'd76799) check("c_last_pixel_ff", ram_data_c, 8'hFF);
      if (q_c.size() == 0) begin
        checks++; failures++;
        $display("FAIL c_unexpected_write: addr %0d, expected no write", ram_wraddr_c);
      end else begin
        e = q_c.pop_front();
        check("c_wr_addr", ram_wraddr_c, e.addr);
        check("c_wr_data", ram_data_c, e.data);
      end
    end
  end

  task automatic wait_done_a(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clock);
      if (done_a) at = cyc;
    end
    check("a_done_seen", (at >= 0), 1);
  endtask

  task automatic wait_writes_a(input int target, input int budget);
    for (int i = 0; i < budget && wr_a < target; i++) begin
      @(negedge clock);
      #1;
    end
  endtask

  initial begin : stim
    int c, c_bc, at, d1, d2, d0, w0, first;
    reset_a = 1'b1; reset_bc = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rom_addr", rom_addr_a, 0);
    check("rst_ram_wraddr", ram_wraddr_a, 0);
    check("rst_ram_data", ram_data_a, 0);
    check("rst_ram_wren", ram_wren_a, 0);
    reset_a = 1'b0; reset_bc = 1'b0;
    @(posedge clock); #1;

    // Frames on b (1:1 copy) and c (full default size) run in the background.
    start_b = 1'b1; start_c = 1'b1; c_bc = cyc;
    push_frame(1); push_frame(2);

    // Single 2x frame with latency and busy-length checks.
    start_a = 1'b1; c = cyc; push_frame(0); busy_cnt_a = 0; d0 = dones_a;
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    check("a_busy_after_accept", busy_a, 1);
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      @(negedge clock);
      if (ram_wren_a) first = cyc;
    end
    check("a_first_write_cycle", first, c + A_L + 3);
    wait_done_a(100, at);
    check("a_done_cycle", at, c + A_N + A_L + 3);
    check("a_busy_low_at_done", busy_a, 0);
    check("a_busy_cycles", busy_cnt_a, A_N + A_L + 2);
    check("a_queue_drained", q_a.size(), 0);
    @(posedge clock); #1;
    check("a_one_done", dones_a - d0, 1);

    // Restart attempts mid-frame and on the done cycle are ignored.
    @(posedge clock); #1;
    start_a = 1'b1; c = cyc; push_frame(0); d0 = dones_a; w0 = wr_a;
    @(posedge clock); #1;
    start_a = 1'b0;
    wait_writes_a(w0 + 10, 100);
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    wait_done_a(100, at);
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    check("a_restart_done_cycle", at, c + A_N + A_L + 3);
    busy_cnt_a = 0;
    repeat (10) @(posedge clock);
    #1;
    check("a_no_restart_busy", busy_cnt_a, 0);
    check("a_restart_single_done", dones_a - d0, 1);
    check("a_restart_queue", q_a.size(), 0);

    // Reset mid-frame, then a clean frame from address 0.
    start_a = 1'b1; push_frame(0); w0 = wr_a;
    @(posedge clock); #1;
    start_a = 1'b0;
    wait_writes_a(w0 + 20, 100);
    @(posedge clock); #1;
    reset_a = 1'b1;
    @(posedge clock); #1;
    reset_a = 1'b0;
    q_a.delete();
    check("a_mid_rst_wren", ram_wren_a, 0);
    check("a_mid_rst_busy", busy_a, 0);
    check("a_mid_rst_done", done_a, 0);
    check("a_mid_rst_rom_addr", rom_addr_a, 0);
    check("a_mid_rst_wraddr", ram_wraddr_a, 0);
    check("a_mid_rst_data", ram_data_a, 0);
    repeat (5) @(posedge clock);
    #1;
    start_a = 1'b1; c = cyc; push_frame(0);
    @(posedge clock); #1;
    start_a = 1'b0;
    wait_done_a(100, at);
    check("a_post_rst_done_cycle", at, c + A_N + A_L + 3);
    check("a_post_rst_queue", q_a.size(), 0);

    // Start held high: back-to-back frames with one IDLE cycle after FIN.
    @(posedge clock); #1;
    start_a = 1'b1; c = cyc; push_frame(0); push_frame(0); d0 = dones_a;
    wait_done_a(100, d1);
    wait_done_a(100, d2);
    start_a = 1'b0;
    check("a_held_first_done", d1, c + A_N + A_L + 3);
    check("a_held_frame_gap", d2 - d1, A_N + A_L + 4);
    repeat (50) @(posedge clock);
    #1;
    check("a_held_two_dones", dones_a - d0, 2);
    check("a_held_queue", q_a.size(), 0);

    // Background frames.
    for (int i = 0; i < 90000 && dones_c == 0; i++) begin
      @(posedge clock); #1;
    end
    repeat (5) @(posedge clock);
    #1;
    check("b_done_count", dones_b, 1);
    check("b_done_cycle", done_cyc_b, c_bc + B_N + B_L + 3);
    check("b_write_count", wr_b, B_N);
    check("b_queue", q_b.size(), 0);
    check("c_done_count", dones_c, 1);
    check("c_done_cycle", done_cyc_c, c_bc + C_N + C_L + 3);
    check("c_write_count", wr_c, C_N);
    check("c_queue", q_c.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
